// File: rtl/telemetry_rx.sv
// rtl/telemetry_rx.sv - telemetry packet parser fed by UART_rx byte handshake
// Optional stale timeout built only when TELEM_TIMEOUT_EN is defined.
module telemetry_rx #(
  parameter int TIMEOUT_CYC = 4194304
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err,
  output logic        stale
);

  typedef enum logic [1:0] {SYNC1, SYNC2, PAYLOAD} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       err, err_nxt;
  logic       accept;
  logic       pkt_done;
  logic       pkt_good;
  logic [3:0] batt_hi, curr_hi, torque_hi;
  logic [7:0] batt_lo, curr_lo;

  // A byte still flagged while clr_rdy is high has already been consumed.
  assign accept   = rx_rdy & ~clr_rdy;
  assign pkt_good = pkt_done & ~err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC1;
      idx   <= 3'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = err;
    pkt_done  = 1'b0;
    if (accept) begin
      case (state)
        SYNC1: begin
          if (rx_data == 8'hAA) state_nxt = SYNC2;
        end
        SYNC2: begin
          if (rx_data == 8'h55) begin
            state_nxt = PAYLOAD;
            idx_nxt   = 3'd0;
            err_nxt   = 1'b0;
          end else if (rx_data != 8'hAA) begin
            state_nxt = SYNC1;
          end
        end
        PAYLOAD: begin
          // Even slots carry the 4-bit high part of each field.
          if (!idx[0] && (rx_data[7:4] != 4'h0)) err_nxt = 1'b1;
          if (idx == 3'd5) begin
            state_nxt = SYNC1;
            idx_nxt   = 3'd0;
            pkt_done  = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
        default: state_nxt = SYNC1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_hi   <= 4'h0;
      batt_lo   <= 8'h00;
      curr_hi   <= 4'h0;
      curr_lo   <= 8'h00;
      torque_hi <= 4'h0;
    end else if (accept && (state == PAYLOAD)) begin
      case (idx)
        3'd0:    batt_hi   <= rx_data[3:0];
        3'd1:    batt_lo   <= rx_data;
        3'd2:    curr_hi   <= rx_data[3:0];
        3'd3:    curr_lo   <= rx_data;
        3'd4:    torque_hi <= rx_data[3:0];
        default: ;
      endcase
    end
  end

  // The final byte goes straight into avg_torque so all three fields load together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_rdy    <= 1'b0;
      pkt_vld    <= 1'b0;
      pkt_err    <= 1'b0;
      batt_v     <= 12'h000;
      avg_curr   <= 12'h000;
      avg_torque <= 12'h000;
    end else begin
      clr_rdy <= accept;
      pkt_vld <= pkt_good;
      pkt_err <= pkt_done & err_nxt;
      if (pkt_good) begin
        batt_v     <= {batt_hi, batt_lo};
        avg_curr   <= {curr_hi, curr_lo};
        avg_torque <= {torque_hi, rx_data};
      end
    end
  end

`ifdef TELEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] tmo_cnt;

  // stale stays set from reset until the first good packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      stale   <= 1'b1;
    end else if (pkt_good) begin
      tmo_cnt <= '0;
      stale   <= 1'b0;
    end else if (tmo_cnt != CNT_MAX) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (tmo_cnt == (CNT_MAX - CNT_W'(1))) stale <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stale <= 1'b1;
    else        stale <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_telemetry_rx.sv
// tb/tb_telemetry_rx.sv - self-checking bench for telemetry_rx
// Stale checks follow TELEM_TIMEOUT_EN the same way the design does.
module tb_telemetry_rx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rdy;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, pkt_err, stale;

  int pass_cnt = 0;
  int total    = 0;

  int n_clr = 0, n_vld = 0, n_err = 0, n_viol = 0;
  logic prev_clr = 1'b0, prev_vld = 1'b0, prev_err = 1'b0;
  logic vld_stale = 1'b1;
  int since = 0;

  logic [7:0] stream[$];

  telemetry_rx #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .clr_rdy(clr_rdy), .batt_v(batt_v), .avg_curr(avg_curr),
    .avg_torque(avg_torque), .pkt_vld(pkt_vld), .pkt_err(pkt_err), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_clr = 0; n_vld = 0; n_err = 0;
    end else begin
      if (clr_rdy) n_clr++;
      if (clr_rdy && prev_clr) n_viol++;
      if (pkt_vld && (pkt_err || prev_vld)) n_viol++;
      if (pkt_err && prev_err) n_viol++;
      if (pkt_vld) begin n_vld++; vld_stale = stale; end
      if (pkt_err) n_err++;
    end
    prev_clr = clr_rdy; prev_vld = pkt_vld; prev_err = pkt_err;
    if (pkt_vld) since = 0; else since++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_rdy = 1'b1; stream.push_back(b);
    wait_cycles(2);
    rx_rdy = 1'b0;
    wait_cycles(gap);
  endtask

  task automatic send_pkt(input logic [7:0] p0, p1, p2, p3, p4, p5, input int gap);
    logic [7:0] p[8];
    p = '{8'hAA, 8'h55, p0, p1, p2, p3, p4, p5};
    for (int i = 0; i < 8; i++) send_byte(p[i], gap);
  endtask

  // Stream-level reference: scan for AA 55 pairs and decode 6 bytes that follow.
  task automatic model(output logic [11:0] b, c, t, output int nv, ne);
    int pos, n;
    logic [7:0] x0, x1, h0, h2, h4;
    b = 12'h0; c = 12'h0; t = 12'h0; nv = 0; ne = 0;
    pos = 0; n = stream.size();
    while (pos + 1 < n) begin
      x0 = stream[pos]; x1 = stream[pos+1];
      if (x0 == 8'hAA && x1 == 8'h55) begin
        if (pos + 7 >= n) break;
        h0 = stream[pos+2]; h2 = stream[pos+4]; h4 = stream[pos+6];
        if (h0 > 8'h0F || h2 > 8'h0F || h4 > 8'h0F) ne++;
        else begin
          nv++;
          b = h0 * 256 + stream[pos+3];
          c = h2 * 256 + stream[pos+5];
          t = h4 * 256 + stream[pos+7];
        end
        pos += 8;
      end else pos++;
    end
  endtask

  task automatic test_reset;
    logic [11:0] z;
    z = 12'h000;
    total++; if ({clr_rdy, pkt_vld, pkt_err} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {clr_rdy, pkt_vld, pkt_err}); else pass_cnt++;
    total++; if ({batt_v, avg_curr, avg_torque} !== {z, z, z}) $display("FAIL reset_fields got %h want 0", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
    total++; if (stale !== 1'b1) $display("FAIL reset_stale got %b want 1", stale); else pass_cnt++;
    rst_n = 1'b1;
    wait_cycles(3);
`ifndef TELEM_TIMEOUT_EN
    total++; if (stale !== 1'b0) $display("FAIL stale_after_reset got %b want 0", stale); else pass_cnt++;
`endif
  endtask

  task automatic test_clean;
    int c0, v0, e0;
    c0 = n_clr; v0 = n_vld; e0 = n_err;
    send_pkt(8'h0A, 8'hBC, 8'h01, 8'h23, 8'h07, 8'hFF, 0);
    wait_cycles(1);
    total++; if (batt_v !== 12'hABC) $display("FAIL clean_batt got %h want abc", batt_v); else pass_cnt++;
    total++; if (avg_curr !== 12'h123) $display("FAIL clean_curr got %h want 123", avg_curr); else pass_cnt++;
    total++; if (avg_torque !== 12'h7FF) $display("FAIL clean_torque got %h want 7ff", avg_torque); else pass_cnt++;
    total++; if (n_vld - v0 !== 1 || n_err - e0 !== 0) $display("FAIL clean_pulses vld %0d err %0d want 1 0", n_vld - v0, n_err - e0); else pass_cnt++;
    total++; if (n_clr - c0 !== 8) $display("FAIL clean_clr_rdy got %0d want 8", n_clr - c0); else pass_cnt++;
    total++; if (vld_stale !== 1'b0) $display("FAIL clean_stale_at_vld got %b want 0", vld_stale); else pass_cnt++;
  endtask

  task automatic test_resync;
    int v0;
    logic [7:0] g[6];
    g = '{8'h13, 8'hAA, 8'h00, 8'hAA, 8'hAA, 8'h55};
    v0 = n_vld;
    for (int i = 0; i < 6; i++) send_byte(g[i], i % 2);
    send_byte(8'h00, 0); send_byte(8'h01, 1); send_byte(8'h00, 0);
    send_byte(8'h02, 2); send_byte(8'h00, 0); send_byte(8'h03, 0);
    wait_cycles(1);
    total++; if (n_vld - v0 !== 1) $display("FAIL resync_vld_count got %0d want 1", n_vld - v0); else pass_cnt++;
    total++; if ({batt_v, avg_curr, avg_torque} !== {12'h001, 12'h002, 12'h003}) $display("FAIL resync_fields got %h want 001002003", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
  endtask

  task automatic test_nibble_err;
    int v0, e0;
    v0 = n_vld; e0 = n_err;
    send_pkt(8'h1A, 8'hBC, 8'h01, 8'h23, 8'h07, 8'hFF, 0);
    wait_cycles(1);
    total++; if (n_err - e0 !== 1 || n_vld - v0 !== 0) $display("FAIL nibble_pulses err %0d vld %0d want 1 0", n_err - e0, n_vld - v0); else pass_cnt++;
    total++; if ({batt_v, avg_curr, avg_torque} !== {12'h001, 12'h002, 12'h003}) $display("FAIL nibble_hold got %h want 001002003", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
    send_pkt(8'h03, 8'h21, 8'h04, 8'h56, 8'h0F, 8'h00, 1);
    total++; if ({batt_v, avg_curr, avg_torque} !== {12'h321, 12'h456, 12'hF00}) $display("FAIL nibble_recover got %h want 321456f00", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
    total++; if (n_vld - v0 !== 1 || n_err - e0 !== 1) $display("FAIL nibble_recover_pulses vld %0d err %0d want 1 1", n_vld - v0, n_err - e0); else pass_cnt++;
  endtask

  task automatic test_sync_lookalike;
    send_pkt(8'h0A, 8'hAA, 8'h05, 8'h55, 8'h00, 8'hAA, 0);
    wait_cycles(1);
    total++; if ({batt_v, avg_curr, avg_torque} !== {12'hAAA, 12'h555, 12'h0AA}) $display("FAIL lookalike_fields got %h want aaa5550aa", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
  endtask

  task automatic test_stale;
`ifdef TELEM_TIMEOUT_EN
    for (int k = 0; k < 300 && since != 99; k++) wait_cycles(1);
    total++; if (since !== 99) $display("FAIL stale_wait_timeout since %0d want 99", since); else pass_cnt++;
    total++; if (stale !== 1'b0) $display("FAIL stale_before_limit got %b want 0", stale); else pass_cnt++;
    wait_cycles(1);
    total++; if (stale !== 1'b1) $display("FAIL stale_at_limit got %b want 1", stale); else pass_cnt++;
    wait_cycles(5);
    send_pkt(8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 0);
    total++; if (vld_stale !== 1'b0 || stale !== 1'b0) $display("FAIL stale_cleared at_vld %b now %b want 0 0", vld_stale, stale); else pass_cnt++;
`else
    wait_cycles(150);
    total++; if (stale !== 1'b0 || vld_stale !== 1'b0) $display("FAIL stale_disabled now %b at_vld %b want 0 0", stale, vld_stale); else pass_cnt++;
`endif
  endtask

  task automatic test_random;
    logic [11:0] eb, ec, et;
    int ev, ee, kind, gap;
    logic [7:0] p[6];
    logic [7:0] look[4];
    look = '{8'hAA, 8'h55, 8'h0A, 8'h05};
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      if (kind == 2) begin
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) send_byte(8'($urandom), gap);
      end else begin
        for (int j = 0; j < 6; j++) begin
          p[j] = 8'($urandom);
          if (j % 2 == 0) p[j][7:4] = 4'h0;
          if (kind == 3) p[j] = look[$urandom_range(0, 3)];
        end
        if (kind == 1) p[2 * $urandom_range(0, 2)][7:4] = 4'($urandom_range(1, 15));
        send_pkt(p[0], p[1], p[2], p[3], p[4], p[5], gap);
      end
      model(eb, ec, et, ev, ee);
      total++; if ({batt_v, avg_curr, avg_torque} !== {eb, ec, et}) $display("FAIL random_fields it %0d got %h want %h", it, {batt_v, avg_curr, avg_torque}, {eb, ec, et}); else pass_cnt++;
      total++; if (n_vld !== ev || n_err !== ee) $display("FAIL random_counts it %0d vld %0d err %0d want %0d %0d", it, n_vld, n_err, ev, ee); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h0A, 0);
    rst_n = 1'b0;
    stream.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    send_byte(8'hBC, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
    send_byte(8'h07, 0); send_byte(8'hFF, 0);
    wait_cycles(2);
    total++; if (n_vld !== 0 || n_err !== 0) $display("FAIL reset_mid_pulses vld %0d err %0d want 0 0", n_vld, n_err); else pass_cnt++;
    total++; if ({batt_v, avg_curr, avg_torque} !== 36'h0) $display("FAIL reset_mid_fields got %h want 0", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
    send_pkt(8'h0F, 8'hED, 8'h00, 8'h01, 8'h08, 8'h00, 0);
    total++; if ({batt_v, avg_curr, avg_torque} !== {12'hFED, 12'h001, 12'h800}) $display("FAIL reset_mid_next got %h want fed001800", {batt_v, avg_curr, avg_torque}); else pass_cnt++;
  endtask

  task automatic test_protocol;
    total++; if (n_viol !== 0) $display("FAIL pulse_protocol violations %0d want 0", n_viol); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    wait_cycles(3);
    test_reset();
    test_clean();
    test_resync();
    test_nibble_err();
    test_sync_lookalike();
    test_stale();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
